// File: rtl/univ_counter.sv
// Modulo-N up/down counter with prescaler, synchronous clear, parallel load
// and wrap / saturate / one-shot / hold count modes. Shared timebase for
// timers, baud generators and debouncers; wrap is a registered pulse for
// cascading, max_tick/min_tick are decoded straight from q.
module univ_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int PRESC_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             max_tick,
  output logic             min_tick,
  output logic             wrap,
  output logic             done
);

  // Reject impossible configurations before anything is built.
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("univ_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (PRESC_DIV < 1) begin : g_bad_presc
    $error("univ_counter: PRESC_DIV must be >= 1");
  end

  // Prescaler needs at least one bit even when it never leaves 0.
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1'b1);
  // Boundary arithmetic is carried one bit wider so MODULUS == 2**WIDTH
  // and the +1/-1 steps never overflow into the count register.
  localparam logic [WIDTH:0]   MOD_V  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_V  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_V  = (WIDTH+1)'(1'b1);
  localparam logic [WIDTH:0]   ZERO_V = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } os_state_t;

  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [PW-1:0]    presc_r, presc_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  os_state_t        state_r, state_nxt_s;

  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH-1:0] q_up_s, q_dn_s, load_val_s;
  logic             at_max_s, at_min_s, step_s;

  // Decode count boundaries, neighbours, load clamp and prescaler step.
  always_comb begin
    q_ext_s    = {1'b0, q_r};
    at_max_s   = (q_ext_s == MAX_V);
    at_min_s   = (q_ext_s == ZERO_V);
    q_up_s     = WIDTH'(q_ext_s + ONE_V);
    q_dn_s     = WIDTH'(q_ext_s - ONE_V);
    load_val_s = ({1'b0, din} >= MOD_V) ? MAX_Q : din;
    step_s     = en && (presc_r == PRESC_LAST);
  end

  // Next-state: clear beats load beats step; step action depends on mode.
  always_comb begin
    q_nxt_s     = q_r;
    presc_nxt_s = presc_r;
    wrap_nxt_s  = 1'b0;
    state_nxt_s = state_r;
    if (clr) begin
      q_nxt_s     = ZERO_Q;
      presc_nxt_s = PRESC_ZERO;
      state_nxt_s = ST_RUN;
    end else if (load) begin
      q_nxt_s     = load_val_s;
      presc_nxt_s = PRESC_ZERO;
      state_nxt_s = ST_RUN;
    end else begin
      if (en) begin
        presc_nxt_s = step_s ? PRESC_ZERO : (presc_r + PRESC_ONE);
      end else begin
        presc_nxt_s = presc_r;
      end
      if (step_s) begin
        case (mode)
          2'b00: begin
            if (up) begin
              q_nxt_s    = at_max_s ? ZERO_Q : q_up_s;
              wrap_nxt_s = at_max_s;
            end else begin
              q_nxt_s    = at_min_s ? MAX_Q : q_dn_s;
              wrap_nxt_s = at_min_s;
            end
          end
          2'b01: begin
            if (up) begin
              q_nxt_s = at_max_s ? q_r : q_up_s;
            end else begin
              q_nxt_s = at_min_s ? q_r : q_dn_s;
            end
          end
          2'b10: begin
            // Once DONE the count is frozen until clr/load/rst.
            if (state_r == ST_RUN) begin
              if (up) begin
                q_nxt_s = at_max_s ? q_r : q_up_s;
                if (at_max_s || (q_up_s == MAX_Q)) begin
                  state_nxt_s = ST_DONE;
                end else begin
                  state_nxt_s = ST_RUN;
                end
              end else begin
                q_nxt_s = at_min_s ? q_r : q_dn_s;
                if (at_min_s || (q_dn_s == ZERO_Q)) begin
                  state_nxt_s = ST_DONE;
                end else begin
                  state_nxt_s = ST_RUN;
                end
              end
            end else begin
              q_nxt_s = q_r;
            end
          end
          default: begin
            q_nxt_s = q_r;
          end
        endcase
      end else begin
        q_nxt_s = q_r;
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= ZERO_Q;
      presc_r <= PRESC_ZERO;
      wrap_r  <= 1'b0;
      state_r <= ST_RUN;
    end else begin
      q_r     <= q_nxt_s;
      presc_r <= presc_nxt_s;
      wrap_r  <= wrap_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign q        = q_r;
  assign wrap     = wrap_r;
  assign done     = (state_r == ST_DONE);
  assign max_tick = (q_ext_s == MAX_V);
  assign min_tick = (q_ext_s == ZERO_V);

endmodule

// File: tb/tb_univ_counter.sv
// Bench for univ_counter: two instances (prescale 1 and 3, WIDTH=4,
// MODULUS=10) share one stimulus stream and are compared every cycle
// against an integer reference model; directed scenarios first, then
// random stimulus with occasional asynchronous resets.
module tb_univ_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic       up = 1'b1;
  logic [1:0] mode = 2'b00;

  logic [3:0] q1, q3;
  logic       mx1, mn1, wr1, dn1;
  logic       mx3, mn3, wr3, dn3;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0: prescale 1, index 1: prescale 3.
  int m_q[2];
  int m_p[2];
  int m_done[2];
  int m_wrap[2];
  int div[2] = '{1, 3};

  always #5 clk = ~clk;

  univ_counter #(.WIDTH(4), .MODULUS(M), .PRESC_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .din(din),
    .up(up), .mode(mode), .q(q1), .max_tick(mx1), .min_tick(mn1),
    .wrap(wr1), .done(dn1)
  );

  univ_counter #(.WIDTH(4), .MODULUS(M), .PRESC_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .din(din),
    .up(up), .mode(mode), .q(q3), .max_tick(mx3), .min_tick(mn3),
    .wrap(wr3), .done(dn3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_p[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
    end
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      int tgt;
      int stp;
      if (clr) begin
        m_q[k] = 0; m_p[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else if (load) begin
        m_q[k] = (int'(din) >= M) ? M - 1 : int'(din);
        m_p[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        stp = 0;
        if (en) begin
          m_p[k] = m_p[k] + 1;
          if (m_p[k] == div[k]) begin
            m_p[k] = 0;
            stp = 1;
          end
        end
        if (stp == 1) begin
          case (mode)
            2'b00: begin
              if (up) begin
                if (m_q[k] == M - 1) m_wrap[k] = 1;
                m_q[k] = (m_q[k] + 1) % M;
              end else begin
                if (m_q[k] == 0) m_wrap[k] = 1;
                m_q[k] = (m_q[k] + M - 1) % M;
              end
            end
            2'b01: m_q[k] = up ? ((m_q[k] < M - 1) ? m_q[k] + 1 : M - 1)
                               : ((m_q[k] > 0) ? m_q[k] - 1 : 0);
            2'b10: begin
              if (m_done[k] == 0) begin
                m_q[k] = up ? ((m_q[k] < M - 1) ? m_q[k] + 1 : M - 1)
                            : ((m_q[k] > 0) ? m_q[k] - 1 : 0);
                tgt = up ? M - 1 : 0;
                if (m_q[k] == tgt) m_done[k] = 1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  endfunction

  task automatic check_all();
    chk("q_p1",    32'(q1),  m_q[0]);
    chk("max_p1",  32'(mx1), (m_q[0] == M - 1) ? 1 : 0);
    chk("min_p1",  32'(mn1), (m_q[0] == 0) ? 1 : 0);
    chk("wrap_p1", 32'(wr1), m_wrap[0]);
    chk("done_p1", 32'(dn1), m_done[0]);
    chk("q_p3",    32'(q3),  m_q[1]);
    chk("max_p3",  32'(mx3), (m_q[1] == M - 1) ? 1 : 0);
    chk("min_p3",  32'(mn3), (m_q[1] == 0) ? 1 : 0);
    chk("wrap_p3", 32'(wr3), m_wrap[1]);
    chk("done_p3", 32'(dn3), m_done[1]);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    model_reset();
    #2 check_all();
    #5 rst = 1'b0;

    // Wrap up, prescale 1: 0..9 then 0 with a one-cycle wrap pulse.
    mode = 2'b00; up = 1'b1; en = 1'b1;
    cyc(9);
    chk("wrapup_q9", 32'(q1), 9);
    chk("wrapup_max", 32'(mx1), 1);
    cyc(1);
    chk("wrapup_q0", 32'(q1), 0);
    chk("wrapup_pulse", 32'(wr1), 1);
    cyc(1);
    chk("wrapup_pulse_end", 32'(wr1), 0);

    // Wrap down with prescale 3, then freeze with en low.
    clr = 1'b1; cyc(1); clr = 1'b0;
    up = 1'b0;
    cyc(3);
    chk("down_p3_9", 32'(q3), 9);
    en = 1'b0;
    cyc(5);
    chk("down_p3_hold", 32'(q3), 9);
    en = 1'b1;
    cyc(3);
    chk("down_p3_8", 32'(q3), 8);

    // Saturate with load clamp.
    mode = 2'b01; load = 1'b1; din = 4'd15; cyc(1); load = 1'b0;
    chk("clamp_q", 32'(q1), 9);
    up = 1'b1;
    cyc(4);
    chk("sat_q", 32'(q1), 9);
    chk("sat_wrap", 32'(wr1), 0);
    up = 1'b0;
    cyc(1);
    chk("sat_down", 32'(q1), 8);

    // One-shot from 7 upwards.
    mode = 2'b10; up = 1'b1; load = 1'b1; din = 4'd7; cyc(1); load = 1'b0;
    cyc(2);
    chk("os_q", 32'(q1), 9);
    chk("os_done", 32'(dn1), 1);
    cyc(3);
    chk("os_frozen", 32'(q1), 9);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("os_clr_done", 32'(dn1), 0);
    cyc(2);
    chk("os_resume", 32'(q1), 2);

    // Priority: clr over load over step.
    mode = 2'b00; clr = 1'b1; load = 1'b1; din = 4'd5; en = 1'b1;
    cyc(1);
    chk("prio_clr", 32'(q1), 0);
    clr = 1'b0;
    cyc(1);
    chk("prio_load", 32'(q1), 5);
    load = 1'b0;

    // Asynchronous reset between edges with q=6.
    load = 1'b1; din = 4'd6; cyc(1); load = 1'b0; en = 1'b0;
    chk("areset_pre", 32'(q1), 6);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    chk("areset_q", 32'(q1), 0);
    #1 rst = 1'b0;

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      clr  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 19) == 0);
      din  = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      cyc(1);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        #1 rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
